// File: rtl/shifter_pkg.sv
// ============================================================================
// Module   : shifter_pkg
// Brief    : Shift-mode encodings shared by the pipelined barrel shifter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package shifter_pkg;

  typedef logic [1:0] sh_mode_t;

  localparam sh_mode_t SH_LSL = 2'b00;
  localparam sh_mode_t SH_LSR = 2'b01;
  localparam sh_mode_t SH_ASR = 2'b10;
  localparam sh_mode_t SH_ROR = 2'b11;

endpackage : shifter_pkg

`default_nettype wire

// File: rtl/shift_stage.sv
// ============================================================================
// Module   : shift_stage
// Brief    : One combinational barrel-shifter level, fixed distance DIST.
//            Rotate path only exists when ROTATE_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  sh_mode_t         mode,
  input  logic             enable,
  output logic [WIDTH-1:0] shifted
);

  always_comb begin
    shifted = data;
    if (enable) begin
      case (mode)
        SH_LSL:  shifted = {data[WIDTH-DIST-1:0], {DIST{1'b0}}};
        SH_LSR:  shifted = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
        SH_ASR:  shifted = {{DIST{data[WIDTH-1]}}, data[WIDTH-1:DIST]};
`ifdef ROTATE_EN
        default: shifted = {data[DIST-1:0], data[WIDTH-1:DIST]};
`else
        // Without rotate wiring, mode 11 degrades to a logical right shift.
        default: shifted = {{DIST{1'b0}}, data[WIDTH-1:DIST]};
`endif
      endcase
    end
  end

endmodule : shift_stage

`default_nettype wire

// File: rtl/pipelined_barrel_shifter.sv
// ============================================================================
// Module   : pipelined_barrel_shifter
// Brief    : log2(WIDTH)-stage pipelined shifter (LSL/LSR/ASR, ROR when
//            ROTATE_EN is defined) with a global-stall valid/ready pipeline.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  sh_mode_t         sh_mode,
  input  logic [AW-1:0]    sh_amt,
  input  logic [WIDTH-1:0] d_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d_out,
  output sh_mode_t         out_mode
);

  logic             w_advance;
  logic [AW-1:0]    w_en;
  logic [WIDTH-1:0] w_stage_in   [AW];
  sh_mode_t         w_stage_mode [AW];
  logic [WIDTH-1:0] w_shifted    [AW];

  logic [AW-1:0]    r_vld;
  logic [WIDTH-1:0] r_data [AW];
  sh_mode_t         r_mode [AW];

  // Whole pipe moves or whole pipe holds; only the tail decides.
  assign w_advance = !r_vld[AW-1] || out_ready;
  assign in_ready  = w_advance;
  assign w_en[0]   = sh_amt[0];

  generate
    for (genvar k = 0; k < AW; k++) begin : g_stage
      if (k == 0) begin : g_head
        assign w_stage_in[k]   = d_in;
        assign w_stage_mode[k] = sh_mode;
      end else begin : g_tail
        assign w_stage_in[k]   = r_data[k-1];
        assign w_stage_mode[k] = r_mode[k-1];
      end

      shift_stage #(
        .WIDTH (WIDTH),
        .DIST  (1 << k)
      ) u_shift (
        .data    (w_stage_in[k]),
        .mode    (w_stage_mode[k]),
        .enable  (w_en[k]),
        .shifted (w_shifted[k])
      );
    end

    // Stage k carries only the amount bits still to be applied, right-aligned.
    for (genvar k = 0; k < AW-1; k++) begin : g_amt
      logic [AW-2-k:0] r_amt;
      logic [AW-2-k:0] w_amt_nxt;

      if (k == 0) begin : g_head
        assign w_amt_nxt = sh_amt[AW-1:1];
      end else begin : g_tail
        assign w_amt_nxt = g_amt[k-1].r_amt[AW-1-k:1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_amt <= '0;
        end else if (w_advance) begin
          r_amt <= w_amt_nxt;
        end
      end

      assign w_en[k+1] = r_amt[0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int k = 0; k < AW; k++) begin
        r_data[k] <= '0;
        r_mode[k] <= SH_LSL;
      end
    end else if (w_advance) begin
      r_vld     <= {r_vld[AW-2:0], in_valid};
      r_data[0] <= w_shifted[0];
      r_mode[0] <= sh_mode;
      for (int k = 1; k < AW; k++) begin
        r_data[k] <= w_shifted[k];
        r_mode[k] <= r_mode[k-1];
      end
    end
  end

  assign out_valid = r_vld[AW-1];
  assign d_out     = r_data[AW-1];
  assign out_mode  = r_mode[AW-1];

endmodule : pipelined_barrel_shifter

`default_nettype wire

// File: tb/tb_pipelined_barrel_shifter.sv
// ============================================================================
// Module   : tb_pipelined_barrel_shifter
// Brief    : Scoreboard bench for pipelined_barrel_shifter (WIDTH = 32),
//            directed scenarios followed by a random stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipelined_barrel_shifter;
  import shifter_pkg::*;

  localparam int W  = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [W-1:0] d;
    sh_mode_t     m;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  sh_mode_t      sh_mode;
  logic [AW-1:0] sh_amt;
  logic [W-1:0]  d_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  d_out;
  sh_mode_t      out_mode;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;

  pipelined_barrel_shifter #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sh_mode   (sh_mode),
    .sh_amt    (sh_amt),
    .d_in      (d_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d_out     (d_out),
    .out_mode  (out_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Behavioural reference: shifts expressed with plain operators.
  function automatic logic [W-1:0] model(input sh_mode_t m, input int a, input logic [W-1:0] d);
    logic signed [W-1:0] s;
    s = d;
    case (m)
      SH_LSL: return d << a;
      SH_LSR: return d >> a;
      SH_ASR: return s >>> a;
      default: begin
`ifdef ROTATE_EN
        if (a == 0) return d;
        return (d >> a) | (d << (W - a));
`else
        return d >> a;
`endif
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: apply inputs, record acceptance, advance to next negedge.
  task automatic drive(input logic v, input sh_mode_t m, input int a, input logic [W-1:0] d);
    exp_t e;
    in_valid = v;
    sh_mode  = m;
    sh_amt   = AW'(a);
    d_in     = d;
    #1;
    if (v && in_ready) begin
      e.d = model(m, a, d);
      e.m = m;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, SH_LSL, 0, '0);
  endtask

  // Monitor: a transfer happens on the next posedge when valid && ready.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", d_out, 'x);
      end else begin
        e = exp_q.pop_front();
        check("result_data", d_out, e.d);
        check("result_mode", W'(out_mode), W'(e.m));
      end
    end
  end

  initial begin
    logic [W-1:0] held_d;
    sh_mode_t     held_m;
    int           lat;
    logic         ov [12];

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sh_mode   = SH_LSL;
    sh_amt    = '0;
    d_in      = '0;
    out_ready = 1'b1;

    #3;
    check("reset_out_valid", W'(out_valid), '0);
    check("reset_d_out", d_out, '0);
    check("reset_out_mode", W'(out_mode), '0);
    check("reset_in_ready", W'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Latency: single LSL 1 << 31.
    drive(1'b1, SH_LSL, 31, 32'h0000_0001);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency_cycles", W'(lat), W'(AW));
    idle(2);

    // Mode patterns.
    drive(1'b1, SH_LSR, 4, 32'h8000_00F0);
    drive(1'b1, SH_ASR, 4, 32'h8000_00F0);
    drive(1'b1, SH_ROR, 4, 32'h8000_00F0);
    drive(1'b1, SH_ROR, 4, 32'h0000_000F);
    drive(1'b1, SH_ASR, 0, 32'h8123_4567);
    drive(1'b1, SH_ROR, 0, 32'hDEAD_BEEF);
    drive(1'b1, SH_ASR, 31, 32'h8000_0000);
    idle(8);

    // Back-to-back stream of LSL amounts 0..7.
    for (int i = 0; i < 8; i++) drive(1'b1, SH_LSL, i, 32'h1);
    idle(8);
    check("stream_drained", W'(exp_q.size()), '0);

    // Backpressure: hold the first result for three cycles.
    for (int i = 0; i < 3; i++) drive(1'b1, SH_LSR, i + 1, 32'hF000_0000);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    out_ready = 1'b0;
    held_d = d_out;
    held_m = out_mode;
    check("bp_valid_seen", W'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_d_out_stable", d_out, held_d);
      check("bp_mode_stable", W'(out_mode), W'(held_m));
      check("bp_valid_stable", W'(out_valid), 32'd1);
      check("bp_in_ready_low", W'(in_ready), '0);
    end
    out_ready = 1'b1;
    idle(8);
    check("bp_drained", W'(exp_q.size()), '0);

    // Reset with three requests in flight: none may reappear.
    for (int i = 0; i < 3; i++) drive(1'b1, SH_LSL, i, 32'hA5A5_0001);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", W'(out_valid), '0);
    check("rst_mid_d_out", d_out, '0);
    check("rst_mid_in_ready", W'(in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle(10);

    // Bubble: valid pattern 1,0,1 must emerge AW cycles later.
    for (int i = 0; i < 12; i++) begin
      ov[i] = out_valid;
      drive((i == 0) || (i == 2), SH_ROR, i, 32'h1234_5678);
    end
    check("bubble_t4", W'(ov[AW-1]), '0);
    check("bubble_t5", W'(ov[AW]), 32'd1);
    check("bubble_t6", W'(ov[AW+1]), '0);
    check("bubble_t7", W'(ov[AW+2]), 32'd1);
    check("bubble_t8", W'(ov[AW+3]), '0);

    // Random stream with random backpressure.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 3) != 0), sh_mode_t'($urandom_range(0, 3)),
            $urandom_range(0, W - 1), $urandom);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    check("final_drained", W'(exp_q.size()), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_pipelined_barrel_shifter

`default_nettype wire
